// File: rtl/fp_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_collector_pkg
// Brief    : Shared widths, typedefs and saturation limits for FMA consumers.
// Revision : 1.0 - initial release
// ============================================================================
package fp_collector_pkg;

    localparam int C_DEF_IBITS   = 12;
    localparam int C_DEF_FBITS   = 20;
    localparam int C_DEF_ID_BITS = 4;

    localparam int C_SINGLE_W = C_DEF_IBITS + C_DEF_FBITS;
    localparam int C_DOUBLE_W = 2 * C_SINGLE_W;
    localparam int C_RESULT_W = C_DOUBLE_W + 1;

    typedef logic signed [C_SINGLE_W-1:0] single_t;
    typedef logic signed [C_DOUBLE_W-1:0] double_t;
    typedef logic signed [C_RESULT_W-1:0] result_t;

    localparam single_t C_SAT_MAX = {1'b0, {(C_SINGLE_W-1){1'b1}}};
    localparam single_t C_SAT_MIN = {1'b1, {(C_SINGLE_W-1){1'b0}}};

endpackage
`default_nettype wire

// File: rtl/fp_round_saturate.sv
`default_nettype none
// ============================================================================
// Module   : fp_round_saturate
// Brief    : Rounds a full-width FMA result half-up and saturates to single width.
// Revision : 1.0 - initial release
// ============================================================================
module fp_round_saturate
    import fp_collector_pkg::*;
#(
    parameter int ibits = C_DEF_IBITS,
    parameter int fbits = C_DEF_FBITS
) (
    input  logic [2*(ibits+fbits):0] r,
    output logic [ibits+fbits-1:0]   odata,
    output logic                     osat
);

    localparam int c_sw = ibits + fbits;
    localparam int c_rw = 2 * c_sw + 1;
    localparam int c_tw = c_rw + 1;

    localparam logic signed [c_tw-1:0] c_half  = c_tw'(1) << (fbits - 1);
    localparam logic signed [c_tw-1:0] c_max_t = {{(c_tw-c_sw+1){1'b0}}, {(c_sw-1){1'b1}}};
    localparam logic signed [c_tw-1:0] c_min_t = {{(c_tw-c_sw+1){1'b1}}, {(c_sw-1){1'b0}}};

    logic signed [c_tw-1:0] w_sum;
    logic signed [c_tw-1:0] w_t;

    // One guard bit keeps the rounding add from overflowing.
    assign w_sum = $signed({r[c_rw-1], r}) + c_half;
    assign w_t   = w_sum >>> fbits;

    always_comb begin
        odata = w_t[c_sw-1:0];
        osat  = 1'b0;
        if (w_t > c_max_t) begin
            odata = {1'b0, {(c_sw-1){1'b1}}};
            osat  = 1'b1;
        end else if (w_t < c_min_t) begin
            odata = {1'b1, {(c_sw-1){1'b0}}};
            osat  = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : fp_result_collector
// Brief    : Id allocator and reorder buffer releasing rounded FMA results in order.
// Revision : 1.0 - initial release
// ============================================================================
module fp_result_collector
    import fp_collector_pkg::*;
#(
    parameter int ibits   = C_DEF_IBITS,
    parameter int fbits   = C_DEF_FBITS,
    parameter int id_bits = C_DEF_ID_BITS
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    output logic [id_bits-1:0]       alloc_id,
    input  logic                     rvalid,
    input  logic [2*(ibits+fbits):0] r,
    input  logic [id_bits-1:0]       rid,
    output logic                     rack,
    output logic                     ovalid,
    input  logic                     oready,
    output logic [ibits+fbits-1:0]   odata,
    output logic [id_bits-1:0]       oid,
    output logic                     osat,
    output logic                     err
);

    localparam int                c_slots = 2 ** id_bits;
    localparam int                c_sw    = ibits + fbits;
    localparam logic [id_bits:0]  c_depth = (id_bits+1)'(c_slots);

    logic [id_bits-1:0] r_head;
    logic [id_bits-1:0] r_tail;
    logic [id_bits:0]   r_count;
    logic               r_alloc_ready;
    logic               r_rack;
    logic               r_err;
    logic [c_slots-1:0] r_done;
    logic [c_sw-1:0]    r_val [c_slots];
    logic               r_sat [c_slots];
    logic               r_ovalid;
    logic [c_sw-1:0]    r_odata;
    logic [id_bits-1:0] r_oid;
    logic               r_osat;

    logic               w_alloc;
    logic               w_accept;
    logic [id_bits-1:0] w_rel;
    logic               w_allocated;
    logic               w_legal;
    logic               w_load;
    logic [id_bits:0]   w_count_next;
    logic [c_sw-1:0]    w_rs_data;
    logic               w_rs_sat;

    fp_round_saturate #(
        .ibits (ibits),
        .fbits (fbits)
    ) u_round_saturate (
        .r     (r),
        .odata (w_rs_data),
        .osat  (w_rs_sat)
    );

    assign w_alloc      = alloc_valid && r_alloc_ready;
    assign w_accept     = rvalid && r_rack;
    // An id is live when its distance from tail lies inside the occupied window.
    assign w_rel        = rid - r_tail;
    assign w_allocated  = ({1'b0, w_rel} < r_count);
    assign w_legal      = w_accept && w_allocated && !r_done[rid];
    assign w_load       = r_done[r_tail] && (!r_ovalid || oready);
    assign w_count_next = r_count + {{id_bits{1'b0}}, w_alloc} - {{id_bits{1'b0}}, w_load};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_alloc_ready <= 1'b0;
            r_rack        <= 1'b0;
            r_err         <= 1'b0;
            r_done        <= '0;
            r_ovalid      <= 1'b0;
            r_odata       <= '0;
            r_oid         <= '0;
            r_osat        <= 1'b0;
        end else begin
            r_rack        <= 1'b1;
            r_count       <= w_count_next;
            r_alloc_ready <= (w_count_next < c_depth);
            if (w_alloc)
                r_head <= r_head + id_bits'(1);
            if (w_accept && !w_legal)
                r_err <= 1'b1;
            if (w_legal)
                r_done[rid] <= 1'b1;
            if (w_load) begin
                r_done[r_tail] <= 1'b0;
                r_tail         <= r_tail + id_bits'(1);
                r_ovalid       <= 1'b1;
                r_odata        <= r_val[r_tail];
                r_oid          <= r_tail;
                r_osat         <= r_sat[r_tail];
            end else if (oready) begin
                r_ovalid <= 1'b0;
            end
        end
    end

    // Payload storage needs no reset; done bits guard every read.
    always_ff @(posedge clock) begin
        if (w_legal) begin
            r_val[rid] <= w_rs_data;
            r_sat[rid] <= w_rs_sat;
        end
    end

    assign alloc_ready = r_alloc_ready;
    assign alloc_id    = r_head;
    assign rack        = r_rack;
    assign ovalid      = r_ovalid;
    assign odata       = r_odata;
    assign oid         = r_oid;
    assign osat        = r_osat;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fp_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_result_collector
// Brief    : Scoreboard bench for fp_result_collector (ibits=4, fbits=4, id_bits=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_result_collector;

    localparam int c_ib  = 4;
    localparam int c_fb  = 4;
    localparam int c_idb = 2;
    localparam int c_sw  = c_ib + c_fb;
    localparam int c_rw  = 2 * c_sw + 1;

    logic             clock;
    logic             reset;
    logic             alloc_valid;
    logic             alloc_ready;
    logic [c_idb-1:0] alloc_id;
    logic             rvalid;
    logic [c_rw-1:0]  r;
    logic [c_idb-1:0] rid;
    logic             rack;
    logic             ovalid;
    logic             oready;
    logic [c_sw-1:0]  odata;
    logic [c_idb-1:0] oid;
    logic             osat;
    logic             err;

    fp_result_collector #(
        .ibits   (c_ib),
        .fbits   (c_fb),
        .id_bits (c_idb)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .alloc_valid (alloc_valid),
        .alloc_ready (alloc_ready),
        .alloc_id    (alloc_id),
        .rvalid      (rvalid),
        .r           (r),
        .rid         (rid),
        .rack        (rack),
        .ovalid      (ovalid),
        .oready      (oready),
        .odata       (odata),
        .oid         (oid),
        .osat        (osat),
        .err         (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;

    // Scoreboard: allocation sequence numbers in release order, payloads keyed by sequence.
    int               exp_q[$];
    logic [c_sw-1:0]  exp_d[int];
    bit               exp_s[int];
    logic [c_idb-1:0] exp_id[int];
    int               seq_next = 0;
    int               seq_of_id[4];
    logic [c_idb-1:0] m_head = '0;
    logic [c_idb-1:0] pending[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference rounding: floor((v + 2^(fb-1)) / 2^fb) then clamp to the signed range.
    task automatic model(input int v, output logic [c_sw-1:0] d, output bit s);
        longint t;
        longint q;
        longint maxv;
        longint minv;
        maxv = (longint'(1) <<< (c_sw - 1)) - 1;
        minv = -(longint'(1) <<< (c_sw - 1));
        t = longint'(v) + (longint'(1) <<< (c_fb - 1));
        if (t >= 0) q = t / (longint'(1) <<< c_fb);
        else        q = -((-t + (longint'(1) <<< c_fb) - 1) / (longint'(1) <<< c_fb));
        if (q > maxv) begin
            d = maxv[c_sw-1:0];
            s = 1'b1;
        end else if (q < minv) begin
            d = minv[c_sw-1:0];
            s = 1'b1;
        end else begin
            d = q[c_sw-1:0];
            s = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic record_alloc(output logic [c_idb-1:0] id);
        chk("alloc_id", alloc_id, m_head);
        id = m_head;
        seq_of_id[m_head] = seq_next;
        exp_id[seq_next]  = m_head;
        exp_q.push_back(seq_next);
        seq_next++;
        m_head = m_head + 1'b1;
    endtask

    task automatic alloc_one(output logic [c_idb-1:0] id);
        int n;
        n = 0;
        id = '0;
        alloc_valid = 1'b1;
        while (!alloc_ready && n < 50) begin
            step();
            n++;
        end
        if (!alloc_ready) begin
            checks++;
            errors++;
            $display("FAIL alloc_timeout: alloc_ready=%0b expected 1", alloc_ready);
        end else begin
            record_alloc(id);
        end
        step();
        alloc_valid = 1'b0;
    endtask

    task automatic drive_result(input logic [c_idb-1:0] id, input int v);
        logic [31:0] vv;
        vv = v;
        rvalid = 1'b1;
        rid    = id;
        r      = vv[c_rw-1:0];
    endtask

    task automatic expect_result(input logic [c_idb-1:0] id, input int v);
        logic [c_sw-1:0] d;
        bit s;
        model(v, d, s);
        exp_d[seq_of_id[id]] = d;
        exp_s[seq_of_id[id]] = s;
    endtask

    task automatic send(input logic [c_idb-1:0] id, input int v);
        expect_result(id, v);
        drive_result(id, v);
        step();
        rvalid = 1'b0;
    endtask

    task automatic send_bad(input logic [c_idb-1:0] id, input int v);
        drive_result(id, v);
        step();
        rvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        oready = 1'b1;
        while ((exp_q.size() != 0 || ovalid) && n < 100) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d outputs outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        logic [c_idb-1:0] id;
        alloc_valid = 1'b0;
        rvalid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_ovalid", ovalid, 0);
        chk("rst_rack", rack, 0);
        chk("rst_alloc_ready", alloc_ready, 0);
        chk("rst_err", err, 0);
        exp_q.delete();
        pending.delete();
        m_head = '0;
        step();
        reset = 1'b0;
        step();
        chk("post_rst_alloc_id", alloc_id, 0);
        chk("post_rst_rack", rack, 1);
        id = '0;
    endtask

    // Monitor: pops the scoreboard on every transfer and checks hold stability under stall.
    logic [c_sw+c_idb:0] held;
    bit                  holding = 1'b0;
    always @(negedge clock) begin
        int s;
        if (reset || !ovalid) begin
            holding = 1'b0;
        end else begin
            if (holding)
                chk("hold_stable", {odata, oid, osat}, held);
            if (oready) begin
                holding = 1'b0;
                xfers++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: oid=%0d odata=0x%0h with empty scoreboard", oid, odata);
                end else begin
                    s = exp_q.pop_front();
                    chk("oid", oid, exp_id[s]);
                    if (!exp_d.exists(s)) begin
                        checks++;
                        errors++;
                        $display("FAIL early_out: oid=%0d released before its result, expected wait", oid);
                    end else begin
                        chk("odata", odata, exp_d[s]);
                        chk("osat", osat, exp_s[s]);
                    end
                end
            end else begin
                holding = 1'b1;
                held = {odata, oid, osat};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [c_idb-1:0] ids[5];
        logic [c_idb-1:0] id;
        logic [c_sw-1:0]  saved;
        int x0;

        reset = 1'b1;
        alloc_valid = 1'b0;
        rvalid = 1'b0;
        r = '0;
        rid = '0;
        oready = 1'b1;
        repeat (2) step();
        chk("reset_alloc_ready", alloc_ready, 0);
        chk("reset_alloc_id", alloc_id, 0);
        chk("reset_rack", rack, 0);
        chk("reset_ovalid", ovalid, 0);
        chk("reset_odata", odata, 0);
        chk("reset_oid", oid, 0);
        chk("reset_osat", osat, 0);
        chk("reset_err", err, 0);
        reset = 1'b0;
        step();
        chk("rack_after_reset", rack, 1);
        chk("ready_after_reset", alloc_ready, 1);

        // In-order basic fill to full.
        for (int i = 0; i < 4; i++) alloc_one(ids[i]);
        chk("full_alloc_ready", alloc_ready, 0);
        send(ids[0], 768);
        step();
        chk("ready_after_release", alloc_ready, 1);
        send(ids[1], 24);
        send(ids[2], 8);
        send(ids[3], -8);
        drain();

        // Out of order: nothing leaves until the head id returns.
        for (int i = 0; i < 3; i++) alloc_one(ids[i]);
        send(ids[2], int'($urandom_range(0, 4095)) - 2048);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ooo_no_output", ovalid, 0);
        end
        send(ids[0], int'($urandom_range(0, 4095)) - 2048);
        send(ids[1], int'($urandom_range(0, 4095)) - 2048);
        drain();

        // Saturation both ways.
        alloc_one(ids[0]);
        alloc_one(ids[1]);
        send(ids[0], 3200);
        send(ids[1], -3200);
        drain();

        // Backpressure with a full buffer.
        oready = 1'b0;
        for (int i = 0; i < 4; i++) alloc_one(ids[i]);
        for (int i = 0; i < 4; i++) send(ids[i], int'($urandom_range(0, 2047)) - 1024);
        step();
        chk("bp_ovalid", ovalid, 1);
        alloc_one(ids[4]);
        chk("bp_alloc_ready", alloc_ready, 0);
        saved = odata;
        repeat (3) step();
        chk("bp_odata_stable", odata, saved);
        chk("bp_ovalid_held", ovalid, 1);
        x0 = xfers;
        oready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("bp_consecutive", ovalid, 1);
        end
        @(posedge clock);
        #1;
        oready = 1'b0;
        @(negedge clock);
        chk("bp_xfer_count", xfers - x0, 4);
        step();
        send(ids[4], 40);
        drain();

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            bit newly;
            int k;
            int v;
            newly = 1'b0;
            oready = ($urandom_range(0, 9) < 7);
            alloc_valid = $urandom_range(0, 1);
            if (alloc_valid && alloc_ready) begin
                record_alloc(id);
                newly = 1'b1;
            end
            if (pending.size() > 0 && $urandom_range(0, 9) < 6) begin
                k = $urandom_range(0, pending.size() - 1);
                if ($urandom_range(0, 1) == 1) v = int'($urandom_range(0, 131071)) - 65536;
                else                           v = int'($urandom_range(0, 8191)) - 4096;
                expect_result(pending[k], v);
                drive_result(pending[k], v);
                pending.delete(k);
            end else begin
                rvalid = 1'b0;
            end
            step();
            rvalid = 1'b0;
            if (newly) pending.push_back(id);
        end
        alloc_valid = 1'b0;
        while (pending.size() > 0) begin
            id = pending.pop_front();
            send(id, int'($urandom_range(0, 131071)) - 65536);
        end
        drain();
        chk("random_no_err", err, 0);

        // Protocol errors: unallocated id, then duplicate of a pending id.
        do_reset();
        alloc_one(ids[0]);
        send_bad(2'd1, 100);
        chk("err_unalloc", err, 1);
        repeat (2) begin
            step();
            chk("err_no_output", ovalid, 0);
        end
        send(ids[0], 160);
        drain();
        send_bad(ids[0], 160);
        chk("err_dup_sticky", err, 1);
        do_reset();
        oready = 1'b0;
        for (int i = 0; i < 3; i++) alloc_one(ids[i]);
        send(ids[1], 48);
        send_bad(ids[1], 48);
        step();
        chk("err_dup_done", err, 1);
        send(ids[0], 16);
        send(ids[2], -16);
        drain();

        // Reset in the middle of outstanding work.
        alloc_one(ids[0]);
        alloc_one(ids[1]);
        do_reset();
        alloc_one(ids[0]);
        send(ids[0], 333);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_result_collector.md
# fp_result_collector

Receiving end of the fixed-point FMA handshake. Hands out transaction ids to the issuing logic, accepts tagged full-width FMA results in any order, and rounds and saturates each result back to single width. Results are released strictly in allocation order. It sits between one or more `fp_fma` instances and the downstream RANSAC datapath, which consumes single-width values.

## Interface
Parameters:
- `ibits`, 12, integer bits of a single-width value
- `fbits`, 20, fraction bits of a single-width value
- `id_bits`, 4, id width; reorder depth is `2**id_bits` slots

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `alloc_valid`  in  1  issuer requests an id
- `alloc_ready`  out  1  a free slot exists; reset 0
- `alloc_id`  out  id_bits  id granted when `alloc_valid && alloc_ready`; reset 0
- `rvalid`  in  1  FMA result valid (FMA `ovalid`)
- `r`  in  2*(ibits+fbits)+1  signed result, 2*fbits fraction bits
- `rid`  in  id_bits  FMA `oid`
- `rack`  out  1  result accepted (FMA `oacknowledge`); reset 0
- `ovalid`  out  1  output word valid; reset 0
- `oready`  in  1  downstream accepts
- `odata`  out  ibits+fbits  rounded, saturated signed result; reset 0
- `oid`  out  id_bits  id of `odata`; reset 0
- `osat`  out  1  `odata` was saturated; reset 0
- `err`  out  1  sticky protocol error; reset 0

## Operation
- State:
  - `head` (next id to allocate)
  - `tail` (next id to release)
  - `count` (0..depth)
  - per slot: `done` bit and stored rounded value plus sat flag
- Allocation:
  - `alloc_id = head`, `alloc_ready = (count < depth)`.
  - On handshake, `head` increments modulo depth and `count` increments.
- Result intake:
  - `rack` is registered and goes to 1 on the first edge after reset deasserts. It then stays 1; the slot for any legal id is always reserved.
  - On `rvalid && rack`, a legal result (slot allocated and `done` clear) is rounded and saturated, then written to slot `rid` with `done` set.
  - A result for an unallocated slot or an already-`done` slot is dropped and sets `err`. `err` clears only on reset.
- Round/saturate:
  - `t = (r + 2**(fbits-1)) >>> fbits`, computed at `r` width plus 1 (round half toward +inf).
  - If `t > 2**(ibits+fbits-1)-1`, output max and set sat.
  - If `t < -2**(ibits+fbits-1)`, output min and set sat.
  - Otherwise output the low ibits+fbits bits of `t`.
- Release:
  - The output register loads slot `tail` when `done[tail]` and the register is empty or draining (`ovalid && oready`).
  - On load, `done[tail]` clears, `tail` increments modulo depth and `count` decrements.
- Simultaneous allocate and release in one cycle: `count` is unchanged.
- Full (`count == depth`): `alloc_ready` = 0. Results still accepted.
- Empty: `ovalid` falls after the last transfer.
- Wrap-around: pointers wrap naturally at `2**id_bits`.
- A result written to `tail` in the same cycle as a release check is not seen until the next cycle.

## Timing
- Result sampled at edge E: `done` is set at E, and the output register loads at E+1 if that slot is `tail` and the register is free. Minimum result-to-`ovalid` latency is 2 cycles.
- Full throughput: one release per cycle while `oready` stays high and consecutive slots are `done`.
- `ovalid`, `odata`, `oid` and `osat` hold stable while `ovalid && !oready`.
- `reset` asserted mid-operation immediately clears pointers, `count`, `done`, `ovalid`, `rack`, `alloc_ready` and `err`. In-flight ids are abandoned; the bench must also reset the FMA.

## Structure
- Shared package `fp_collector_pkg`: single, double and result typedefs parameterised by `ibits`/`fbits`, and the saturation min/max constants.
- One combinational sub-module `fp_round_saturate` (`r` in; `odata` and `osat` out), reusable by other FMA consumers.
- Slot storage is a register array; no RAM inference is required at default depth.

## Test plan
All scenarios use ibits=4, fbits=4, id_bits=2.
- In-order basic: allocate ids 0,1,2,3 (alloc_ready then 0). Return r=768 (3.0), 24, 8, -8 in order. Required: odata 0x30, 0x02, 0x01, 0x00 with oid 0..3, and alloc_ready back to 1 after the first release.
- Out-of-order: allocate 0,1,2. Return rid 2, then 0, then 1. Required: outputs appear only after rid 0 arrives, in order 0,1,2, with odata matching each result.
- Saturation: return r=3200 → odata 0x7F, osat=1. Return r=-3200 → odata 0x80, osat=1.
- Backpressure and full: hold oready=0 with 4 results done. Required: ovalid stays 1 with odata stable, and alloc_ready=0. Raise oready for 4 cycles → four transfers on consecutive cycles.
- Error: return rid=1 while only id 0 is allocated. Required: err=1 and no output. A duplicate rid 0 after its first return also keeps err=1.
- Reset mid-run: assert reset with 2 slots pending. Required: ovalid, rack, alloc_ready and err = 0 immediately. After release, alloc_id=0 and rack=1 one cycle later.
